// File: rtl/reverb_ctrl_pkg.sv
// Shared definitions for the reverb tap sequencer: controller states,
// default parameter values and status-vector bit positions.
package reverb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_STREAM,
    ST_WAIT_DONE,
    ST_RUN,
    ST_ERROR
  } ctrl_state_t;

  localparam int DEF_NUM_TAPS_LOG2 = 4;
  localparam int DEF_TAP_WIDTH     = 16;
  localparam int DEF_FLUSH_CYCLES  = 4;
  localparam int DEF_DONE_TIMEOUT  = 64;

  localparam int STAT_BUSY       = 0;
  localparam int STAT_RUNNING    = 1;
  localparam int STAT_LOAD_ERROR = 2;
  localparam int STAT_WR_DROPPED = 3;
  localparam int STAT_W          = 4;

  // States during which a tap load is in flight and the store is locked.
  function automatic logic is_busy_state(input ctrl_state_t s);
    return (s == ST_FLUSH) || (s == ST_STREAM) || (s == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/reverb_tap_ram.sv
// Simple dual-port tap store: one write port, one read port with a
// one-cycle registered read. Array contents are never reset; only the
// read register is, so the tap output starts at zero.
module reverb_tap_ram #(
  parameter int G_ADDR_W = 4,
  parameter int G_DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [G_ADDR_W-1:0] wr_addr,
  input  logic [G_DATA_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [G_ADDR_W-1:0] rd_addr,
  output logic [G_DATA_W-1:0] rd_data
);

  logic [G_DATA_W-1:0] mem [2**G_ADDR_W];
  logic [G_DATA_W-1:0] rd_data_reg;

  // Host write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; holds its value whenever rd_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/reverb_tap_sequencer.sv
// Tap-load controller for the reverb FIR: flushes the datapath, streams
// the tap store to the FIR over a valid/ready link, waits for the FIR's
// load-complete level, then runs with the filter in circuit.
// G_FLUSH_CYCLES and G_DONE_TIMEOUT are expected to be at least 1.
module reverb_tap_sequencer
  import reverb_ctrl_pkg::*;
#(
  parameter int G_NUM_TAPS_LOG2 = DEF_NUM_TAPS_LOG2,
  parameter int G_TAP_WIDTH     = DEF_TAP_WIDTH,
  parameter int G_FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
  parameter int G_DONE_TIMEOUT  = DEF_DONE_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sw_enable,
  input  logic                       load_start,
  input  logic                       tap_wr_en,
  input  logic [G_NUM_TAPS_LOG2-1:0] tap_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     tap_wr_data,
  output logic [G_TAP_WIDTH-1:0]     tap_dout,
  output logic                       tap_dout_valid,
  input  logic                       tap_dout_ready,
  input  logic                       tap_done,
  output logic                       fir_enable,
  output logic                       fir_bypass,
  output logic                       busy,
  output logic                       running,
  output logic                       load_error,
  output logic                       wr_dropped
);

  localparam int CNT_MAX = (G_DONE_TIMEOUT > G_FLUSH_CYCLES) ? G_DONE_TIMEOUT : G_FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]           FLUSH_LAST   = CNT_W'(G_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]           TIMEOUT_LAST = CNT_W'(G_DONE_TIMEOUT - 1);
  localparam logic [G_NUM_TAPS_LOG2-1:0] LAST_IDX     = '1;

  ctrl_state_t                state_reg, state_next;
  logic [CNT_W-1:0]           cnt_reg;
  logic [G_NUM_TAPS_LOG2-1:0] idx_reg;
  logic                       tap_dout_valid_reg;
  logic                       fir_enable_reg;
  logic                       fir_bypass_reg;
  logic [STAT_W-1:0]          status_reg;

  logic                       handshake;
  logic                       load_accept;
  logic                       ram_wr_en;
  logic                       ram_rd_en;
  logic [G_NUM_TAPS_LOG2-1:0] ram_rd_addr;

  assign handshake   = tap_dout_valid_reg & tap_dout_ready;
  assign load_accept = sw_enable & load_start & ~is_busy_state(state_reg);
  // The store is locked for the whole load, so reads never collide with writes.
  assign ram_wr_en   = tap_wr_en & ~is_busy_state(state_reg);

  // Next-state selection; a low sw_enable overrides everything else.
  always_comb begin
    state_next = state_reg;
    if (!sw_enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_RUN, ST_ERROR: if (load_start) state_next = ST_FLUSH;
        ST_FLUSH:     if (cnt_reg == FLUSH_LAST) state_next = ST_STREAM;
        ST_STREAM:    if (handshake && idx_reg == LAST_IDX) state_next = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (tap_done) begin
            state_next = ST_RUN;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_next = ST_ERROR;
          end
        end
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // Prefetch tap 0 on the last flush cycle, then the following tap on each
  // handshake, so the read register always holds the tap being offered.
  always_comb begin
    ram_rd_en   = ((state_reg == ST_FLUSH) && (state_next == ST_STREAM)) ||
                  ((state_reg == ST_STREAM) && (state_next == ST_STREAM) && handshake);
    ram_rd_addr = (state_reg == ST_FLUSH) ? '0 : idx_reg + 1'b1;
  end

  // Controller state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      cnt_reg            <= '0;
      idx_reg            <= '0;
      tap_dout_valid_reg <= 1'b0;
      fir_enable_reg     <= 1'b0;
      fir_bypass_reg     <= 1'b1;
      status_reg         <= '0;
    end else begin
      state_reg <= state_next;

      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (state_reg == ST_FLUSH || state_reg == ST_WAIT_DONE) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (state_next == ST_FLUSH) begin
        idx_reg <= '0;
      end else if (handshake) begin
        idx_reg <= idx_reg + 1'b1;
      end

      tap_dout_valid_reg <= (state_next == ST_STREAM) &&
                            ((state_reg == ST_FLUSH) || tap_dout_valid_reg);
      fir_enable_reg     <= (state_next == ST_STREAM) || (state_next == ST_WAIT_DONE) ||
                            (state_next == ST_RUN);
      fir_bypass_reg     <= (state_next != ST_RUN);

      status_reg[STAT_BUSY]       <= is_busy_state(state_next);
      status_reg[STAT_RUNNING]    <= (state_next == ST_RUN);
      status_reg[STAT_LOAD_ERROR] <= (state_next == ST_ERROR);
      if (load_accept) begin
        status_reg[STAT_WR_DROPPED] <= 1'b0;
      end else if (tap_wr_en && is_busy_state(state_reg)) begin
        status_reg[STAT_WR_DROPPED] <= 1'b1;
      end
    end
  end

  reverb_tap_ram #(
    .G_ADDR_W (G_NUM_TAPS_LOG2),
    .G_DATA_W (G_TAP_WIDTH)
  ) u_tap_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_wr_en),
    .wr_addr (tap_wr_addr),
    .wr_data (tap_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (tap_dout)
  );

  assign tap_dout_valid = tap_dout_valid_reg;
  assign fir_enable     = fir_enable_reg;
  assign fir_bypass     = fir_bypass_reg;
  assign busy           = status_reg[STAT_BUSY];
  assign running        = status_reg[STAT_RUNNING];
  assign load_error     = status_reg[STAT_LOAD_ERROR];
  assign wr_dropped     = status_reg[STAT_WR_DROPPED];

endmodule

// File: tb/tb_reverb_tap_sequencer.sv
// Self-checking bench for reverb_tap_sequencer. The reference model is a
// plain array of tap values the host has successfully written; each stream
// is checked against it in address order.
module tb_reverb_tap_sequencer;

  localparam int N_LOG2  = 4;
  localparam int N       = 16;
  localparam int W       = 16;
  localparam int FLUSH   = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              sw_enable;
  logic              load_start;
  logic              tap_wr_en;
  logic [N_LOG2-1:0] tap_wr_addr;
  logic [W-1:0]      tap_wr_data;
  logic [W-1:0]      tap_dout;
  logic              tap_dout_valid;
  logic              tap_dout_ready;
  logic              tap_done;
  logic              fir_enable;
  logic              fir_bypass;
  logic              busy;
  logic              running;
  logic              load_error;
  logic              wr_dropped;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model_taps [N];
  logic [W-1:0] got_q [$];
  int           flush_len;
  int           stall_bad;
  int           mode_bad;
  int           first_valid_cyc;
  bit           stream_timeout;

  always #5 clk = ~clk;

  reverb_tap_sequencer #(
    .G_NUM_TAPS_LOG2 (N_LOG2),
    .G_TAP_WIDTH     (W),
    .G_FLUSH_CYCLES  (FLUSH),
    .G_DONE_TIMEOUT  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sw_enable      (sw_enable),
    .load_start     (load_start),
    .tap_wr_en      (tap_wr_en),
    .tap_wr_addr    (tap_wr_addr),
    .tap_wr_data    (tap_wr_data),
    .tap_dout       (tap_dout),
    .tap_dout_valid (tap_dout_valid),
    .tap_dout_ready (tap_dout_ready),
    .tap_done       (tap_done),
    .fir_enable     (fir_enable),
    .fir_bypass     (fir_bypass),
    .busy           (busy),
    .running        (running),
    .load_error     (load_error),
    .wr_dropped     (wr_dropped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host write while the sequencer is not busy; the model follows it.
  task automatic write_tap(input logic [N_LOG2-1:0] a, input logic [W-1:0] d);
    tap_wr_en   = 1'b1;
    tap_wr_addr = a;
    tap_wr_data = d;
    tick();
    tap_wr_en   = 1'b0;
    model_taps[a] = d;
  endtask

  // One-cycle load request, optionally with a host write in the same cycle.
  task automatic start_load(input bit with_wr, input logic [N_LOG2-1:0] a, input logic [W-1:0] d);
    load_start = 1'b1;
    if (with_wr) begin
      tap_wr_en   = 1'b1;
      tap_wr_addr = a;
      tap_wr_data = d;
    end
    tick();
    load_start = 1'b0;
    tap_wr_en  = 1'b0;
    if (with_wr) model_taps[a] = d;
  endtask

  // Measures the flush phase then collects N handshaken taps into got_q.
  task automatic run_stream(input int ready_pct, input bit inject_wr);
    bit           prev_valid;
    bit           prev_ready;
    logic [W-1:0] prev_dout;
    bit           r;
    int           cyc;
    got_q.delete();
    flush_len       = 0;
    stall_bad       = 0;
    mode_bad        = 0;
    first_valid_cyc = -1;
    stream_timeout  = 0;
    for (int i = 0; i < 20 && busy && !fir_enable; i++) begin
      flush_len++;
      tick();
    end
    prev_valid = 0;
    prev_ready = 0;
    prev_dout  = '0;
    cyc        = 0;
    while (got_q.size() < N) begin
      if (cyc > 400) begin
        stream_timeout = 1;
        break;
      end
      if (!fir_enable || !fir_bypass) mode_bad++;
      if (prev_valid && !prev_ready && (!tap_dout_valid || tap_dout !== prev_dout)) stall_bad++;
      if (tap_dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (inject_wr && cyc == 1) begin
        tap_wr_en   = 1'b1;
        tap_wr_addr = N_LOG2'($urandom_range(N - 1));
        tap_wr_data = ~model_taps[tap_wr_addr];
      end
      r = ($urandom_range(99) < ready_pct);
      tap_dout_ready = r;
      if (tap_dout_valid && r) got_q.push_back(tap_dout);
      prev_valid = tap_dout_valid;
      prev_ready = r;
      prev_dout  = tap_dout;
      tick();
      tap_wr_en = 1'b0;
      cyc++;
    end
    tap_dout_ready = 1'b0;
    $display("load: handshakes=%0d flush=%0d cycles=%0d first_valid=%0d",
             got_q.size(), flush_len, cyc, first_valid_cyc);
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    sw_enable      = 1'b0;
    load_start     = 1'b0;
    tap_wr_en      = 1'b0;
    tap_wr_addr    = '0;
    tap_wr_data    = '0;
    tap_dout_ready = 1'b0;
    tap_done       = 1'b0;
    tick();
    tick();
    total++;
    if ({tap_dout_valid, fir_enable, fir_bypass, busy, running, load_error, wr_dropped} !== 7'b0010000) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 0010000",
               {tap_dout_valid, fir_enable, fir_bypass, busy, running, load_error, wr_dropped});
    end
    total++;
    if (tap_dout !== '0) begin
      bad++;
      $display("FAIL reset_tap_dout: got %h expected 0000", tap_dout);
    end
    @(negedge clk);
    reset     = 1'b0;
    sw_enable = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || fir_bypass !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b bypass=%b expected busy=0 bypass=1", busy, fir_bypass);
    end
  endtask

  task automatic test_basic_load();
    for (int a = 0; a < N; a++) write_tap(N_LOG2'(a), W'(16'h0100 + a));
    tap_done = 1'b0;
    start_load(0, '0, '0);
    run_stream(100, 0);
    total++;
    if (flush_len !== FLUSH) begin
      bad++;
      $display("FAIL basic_flush_len: got %0d expected %0d", flush_len, FLUSH);
    end
    total++;
    if (got_q.size() !== N) begin
      bad++;
      $display("FAIL basic_count: got %0d expected %0d", got_q.size(), N);
    end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== W'(16'h0100 + i)) begin
        bad++;
        $display("FAIL basic_tap%0d: got %h expected %h", i, got_q[i], W'(16'h0100 + i));
      end
    end
    total++;
    if (mode_bad !== 0) begin
      bad++;
      $display("FAIL basic_stream_mode: got %0d bad cycles expected 0", mode_bad);
    end
    total++;
    if (tap_dout_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_after_last: got valid=%b busy=%b expected valid=0 busy=1", tap_dout_valid, busy);
    end
    tap_done = 1'b1;
    tick();
    tap_done = 1'b0;
    total++;
    if ({running, fir_enable, fir_bypass, busy} !== 4'b1100) begin
      bad++;
      $display("FAIL basic_run: got run/en/byp/busy=%b expected 1100", {running, fir_enable, fir_bypass, busy});
    end
  endtask

  task automatic test_random_ready();
    logic [N_LOG2-1:0] same_addr;
    for (int a = 0; a < N; a++) write_tap(N_LOG2'(a), W'($urandom));
    same_addr = N_LOG2'($urandom_range(N - 1));
    tap_done  = 1'b1;
    start_load(1, same_addr, W'($urandom));
    run_stream(50, 0);
    total++;
    if (stream_timeout !== 1'b0 || got_q.size() !== N) begin
      bad++;
      $display("FAIL rand_count: got %0d handshakes expected %0d", got_q.size(), N);
    end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== model_taps[i]) begin
        bad++;
        $display("FAIL rand_tap%0d: got %h expected %h", i, got_q[i], model_taps[i]);
      end
    end
    total++;
    if (stall_bad !== 0) begin
      bad++;
      $display("FAIL rand_stall_stable: got %0d unstable cycles expected 0", stall_bad);
    end
    total++;
    if (first_valid_cyc < 0 || first_valid_cyc > 1) begin
      bad++;
      $display("FAIL rand_first_valid: got cycle %0d expected 0..1", first_valid_cyc);
    end
    total++;
    if (busy !== 1'b1 || tap_dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL rand_wait_done: got busy=%b valid=%b expected busy=1 valid=0", busy, tap_dout_valid);
    end
    tick();
    total++;
    if (running !== 1'b1) begin
      bad++;
      $display("FAIL rand_run: got running=%b expected 1", running);
    end
  endtask

  task automatic test_timeout();
    int k;
    tap_done = 1'b0;
    start_load(0, '0, '0);
    run_stream(100, 0);
    k = 0;
    while (!load_error && k < 200) begin
      tick();
      k++;
    end
    total++;
    if (k !== TIMEOUT) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d expected %0d", k, TIMEOUT);
    end
    total++;
    if ({fir_enable, fir_bypass, busy, running} !== 4'b0100) begin
      bad++;
      $display("FAIL timeout_outputs: got en/byp/busy/run=%b expected 0100", {fir_enable, fir_bypass, busy, running});
    end
    start_load(0, '0, '0);
    total++;
    if (load_error !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_reload: got err=%b busy=%b expected err=0 busy=1", load_error, busy);
    end
    run_stream(100, 0);
    tap_done = 1'b1;
    tick();
    total++;
    if (running !== 1'b1 || got_q.size() !== N || got_q[N-1] !== model_taps[N-1]) begin
      bad++;
      $display("FAIL timeout_recover: got running=%b count=%0d expected running=1 count=%0d", running, got_q.size(), N);
    end
  endtask

  task automatic test_wr_dropped();
    tap_done = 1'b0;
    start_load(0, '0, '0);
    run_stream(50, 1);
    total++;
    if (wr_dropped !== 1'b1) begin
      bad++;
      $display("FAIL wr_dropped_set: got %b expected 1", wr_dropped);
    end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== model_taps[i]) begin
        bad++;
        $display("FAIL dropped_tap%0d: got %h expected %h", i, got_q[i], model_taps[i]);
      end
    end
    tap_done = 1'b1;
    tick();
    start_load(0, '0, '0);
    total++;
    if (wr_dropped !== 1'b0) begin
      bad++;
      $display("FAIL wr_dropped_clear: got %b expected 0", wr_dropped);
    end
    run_stream(100, 0);
    tick();
  endtask

  task automatic test_sw_disable();
    tap_done = 1'b0;
    start_load(0, '0, '0);
    for (int i = 0; i < 20 && !tap_dout_valid; i++) tick();
    tap_dout_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (tap_dout_valid !== 1'b1 || tap_dout !== model_taps[7]) begin
      bad++;
      $display("FAIL sw_tap7: got valid=%b dout=%h expected valid=1 dout=%h", tap_dout_valid, tap_dout, model_taps[7]);
    end
    tap_dout_ready = 1'b0;
    sw_enable      = 1'b0;
    load_start     = 1'b1;
    tick();
    load_start = 1'b0;
    total++;
    if ({tap_dout_valid, fir_enable, fir_bypass, busy, running} !== 5'b00100) begin
      bad++;
      $display("FAIL sw_disable_idle: got val/en/byp/busy/run=%b expected 00100",
               {tap_dout_valid, fir_enable, fir_bypass, busy, running});
    end
    sw_enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_wait_done();
    tap_done = 1'b0;
    start_load(0, '0, '0);
    run_stream(100, 1);
    tick();
    tick();
    total++;
    if (busy !== 1'b1 || wr_dropped !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_state: got busy=%b dropped=%b expected 1 1", busy, wr_dropped);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({tap_dout_valid, fir_enable, fir_bypass, busy, running, load_error, wr_dropped} !== 7'b0010000 ||
        tap_dout !== '0) begin
      bad++;
      $display("FAIL async_reset: got %b dout=%h expected 0010000 dout=0000",
               {tap_dout_valid, fir_enable, fir_bypass, busy, running, load_error, wr_dropped}, tap_dout);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_random_ready();
    test_timeout();
    test_wr_dropped();
    test_sw_disable();
    test_reset_wait_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
